// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder that reuses one full-adder slice,
// built from two HA half-adders and an OR gate, for every operand bit. One
// bit per clock, LSB first, with a carry flop between bits.
//
// Ports:
//   clk_i    - sole clock, rising edge
//   rst_ni   - asynchronous, active-low reset
//   start_i  - request, sampled only in IDLE or DONE
//   a_i, b_i - WIDTH-bit operands, captured on the accepting edge
//   cin_i    - carry-in, captured on the accepting edge
//   busy_o   - high while bits are being processed
//   done_o   - one-cycle pulse, result valid
//   sum_o    - registered result, held until the next completion
//   cout_o   - registered carry-out, held with sum_o

// HA: half adder, s = a ^ b, c = a & b.
module HA (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] aSr_q, aSr_d;
  logic [WIDTH-1:0] bSr_q, bSr_d;
  logic [WIDTH-1:0] rSr_q, rSr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             sliceP, sliceG, sliceS, sliceH, sliceC;
  logic [WIDTH-1:0] rShifted;

  // Full-adder slice: HA(a,b) gives propagate/generate, HA(p,carry) gives
  // the sum bit; either half-adder carry produces the slice carry.
  HA uHaLo (
    .a_i (aSr_q[0]),
    .b_i (bSr_q[0]),
    .s_o (sliceP),
    .c_o (sliceG)
  );

  HA uHaHi (
    .a_i (sliceP),
    .b_i (carry_q),
    .s_o (sliceS),
    .c_o (sliceH)
  );

  assign sliceC = sliceG | sliceH;

  // The new sum bit enters at the MSB so that after WIDTH shifts bit 0
  // has arrived at the LSB. A one-bit result register is just the bit.
  generate
    if (WIDTH == 1) begin : gNarrow
      assign rShifted = sliceS;
    end else begin : gWide
      assign rShifted = {sliceS, rSr_q[WIDTH-1:1]};
    end
  endgenerate

  // State and datapath registers; reset also clears the held result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      aSr_q   <= '0;
      bSr_q   <= '0;
      rSr_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      aSr_q   <= aSr_d;
      bSr_q   <= bSr_d;
      rSr_q   <= rSr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update. DONE accepts a new request exactly
  // like IDLE, which is what allows back-to-back operations.
  always_comb begin
    state_d = state_q;
    aSr_d   = aSr_q;
    bSr_d   = bSr_q;
    rSr_d   = rSr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          aSr_d   = a_i;
          bSr_d   = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        aSr_d   = aSr_q >> 1;
        bSr_d   = bSr_q >> 1;
        rSr_d   = rShifted;
        carry_d = sliceC;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = rShifted;
          cout_d  = sliceC;
          state_d = StDone;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode straight from registers, so no input reaches them
  // combinationally.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    busy_o = (state_q == StRun);
    done_o = (state_q == StDone);
    sum_o  = sum_q;
    cout_o = cout_q;
  end

endmodule
